// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int MAX_STAGES = 8;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational N-bit carry-lookahead adder slice built on a parallel-prefix
// generate/propagate tree; also exposes the carry into its top bit.
module cla_slice #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] gg;
  logic [N-1:0] pp;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // After the prefix tree, gg[i]/pp[i] are group generate/propagate over bits i..0.
  always_comb begin
    gg = g;
    pp = p;
    for (int d = 1; d < N; d = d * 2) begin
      for (int i = N - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i - d]);
        pp[i] = pp[i] & pp[i - d];
      end
    end
  end

  assign c[0] = ci;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_carry
    assign c[gi + 1] = gg[gi] | (pp[gi] & ci);
  end

  assign s     = p ^ c[N-1:0];
  assign co    = c[N];
  assign c_msb = c[N-1];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined adder: one CLA slice per stage, operand skew and result deskew
// registers, valid/ready handshake. Define CLA_OVF_EN to add the ovf output.
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipe_cla_adder: WIDTH must be a multiple of STAGES, STAGES in 1..MAX_STAGES");
  end

  // Reset forces advance so the input side reports ready while clearing.
  logic advance;
  assign advance  = rst || !out_valid || out_ready;
  assign in_ready = advance;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-gi*SW-1:0]   a_src;
    logic [WIDTH-gi*SW-1:0]   b_src;
    logic                     c_src;
    logic                     v_src;
    logic [SW-1:0]            s;
    logic                     co;
    logic                     c_msb;
    logic                     valid_reg;
    logic                     carry_reg;
    logic [(gi+1)*SW-1:0]     sum_reg;
    logic [(gi+1)*SW-1:0]     sum_next;

    if (gi == 0) begin : g_head
      assign a_src    = in_a;
      assign b_src    = in_b;
      assign c_src    = cin;
      assign v_src    = in_valid;
      assign sum_next = s;
    end else begin : g_tail
      assign a_src    = g_stage[gi-1].g_mid.a_reg;
      assign b_src    = g_stage[gi-1].g_mid.b_reg;
      assign c_src    = g_stage[gi-1].carry_reg;
      assign v_src    = g_stage[gi-1].valid_reg;
      assign sum_next = {s, g_stage[gi-1].sum_reg};
    end

    cla_slice #(.N(SW)) u_slice (
      .a     (a_src[SW-1:0]),
      .b     (b_src[SW-1:0]),
      .ci    (c_src),
      .s     (s),
      .co    (co),
      .c_msb (c_msb)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (advance) begin
        valid_reg <= v_src;
        carry_reg <= co;
        sum_reg   <= sum_next;
      end
    end

    if (gi < STAGES - 1) begin : g_mid
      // Operand slices not yet consumed ride along to later stages.
      logic [WIDTH-(gi+1)*SW-1:0] a_reg;
      logic [WIDTH-(gi+1)*SW-1:0] b_reg;
      logic                       unused_c_msb;

      assign unused_c_msb = c_msb;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (advance) begin
          a_reg <= a_src[WIDTH-gi*SW-1:SW];
          b_reg <= b_src[WIDTH-gi*SW-1:SW];
        end
      end
    end else begin : g_last
`ifdef CLA_OVF_EN
      logic ovf_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (advance) begin
          ovf_reg <= c_msb ^ co;
        end
      end
`else
      logic unused_c_msb;
      assign unused_c_msb = c_msb;
`endif
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign sum       = g_stage[STAGES-1].sum_reg;
  assign cout      = g_stage[STAGES-1].carry_reg;
`ifdef CLA_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_last.ovf_reg;
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=64, STAGES=4): vector table,
// hand sequences for latency/stall/reset, random traffic, queue scoreboard.
module tb_pipe_cla_adder;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;
  localparam int NVEC   = 12;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   res_cnt  = 0;
  exp_t exp_q[$];
  vec_t vecs[NVEC];

  pipe_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "simulation time limit reached");
  end

  function automatic exp_t golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c);
    logic [WIDTH:0] t;
    exp_t e;
    t      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    e.sum  = t[WIDTH-1:0];
    e.cout = t[WIDTH];
    e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] req);
    chk_cnt++;
    if (got === req) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, got, req);
  endtask

  task automatic check1(input string name, input logic got, input logic req);
    chk_cnt++;
    if (got === req) pass_cnt++;
    else $display("FAIL %s: got %b required %b", name, got, req);
  endtask

  task automatic checkn(input string name, input int got, input int req);
    chk_cnt++;
    if (got == req) pass_cnt++;
    else $display("FAIL %s: got %0d required %0d", name, got, req);
  endtask

  // Scoreboard: every result handed downstream is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_result: got sum=%h cout=%b required no result", sum, cout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result %0d: sum=%h cout=%b expected sum=%h cout=%b",
                 res_cnt, sum, cout, e.sum, e.cout);
        check("sb_sum", sum, e.sum);
        check1("sb_cout", cout, e.cout);
`ifdef CLA_OVF_EN
        check1("sb_ovf", ovf, e.ovf);
`endif
      end
      res_cnt++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the operand was accepted.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic c, input exp_t e);
    int n;
    in_a     = a;
    in_b     = b;
    cin      = c;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL send_timeout: got in_ready=0 required 1");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkn(name, exp_q.size(), 0);
  endtask

  initial begin
    int   lat;
    int   seen;
    logic [WIDTH-1:0] hold_sum;
    logic             hold_cout;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[1]  = '{64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0};
    vecs[2]  = '{64'h5, 64'h7, 1'b1, 64'hD, 1'b0, 1'b0};
    vecs[3]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[4]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[7]  = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[8]  = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[9]  = '{64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[10] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                 64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vecs[11] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};

    // Reset with downstream stalled: ready must still be high, outputs cleared.
    @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, '0);
    check1("rst_cout", cout, 1'b0);
`ifdef CLA_OVF_EN
    check1("rst_ovf", ovf, 1'b0);
`endif
    rst       = 1'b0;
    out_ready = 1'b1;
    check1("post_rst_in_ready", in_ready, 1'b1);

    // Single op latency, all-ones + 0 + 1.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, golden(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1));
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkn("latency", lat, STAGES);
    check("lat_sum", sum, 64'h0);
    check1("lat_cout", cout, 1'b1);
    drain("drain_latency");

    // Three back-to-back ops emerge on consecutive cycles.
    send(64'h1, 64'h2, 1'b0, golden(64'h1, 64'h2, 1'b0));
    send(64'h5, 64'h7, 1'b1, golden(64'h5, 64'h7, 1'b1));
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
         golden(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check1("b2b_v0", out_valid, 1'b1);
    check("b2b_sum0", sum, 64'd3);
    @(posedge clk);
    #1;
    check1("b2b_v1", out_valid, 1'b1);
    check("b2b_sum1", sum, 64'd13);
    @(posedge clk);
    #1;
    check1("b2b_v2", out_valid, 1'b1);
    check("b2b_sum2", sum, 64'd0);
    check1("b2b_cout2", cout, 1'b1);
    @(posedge clk);
    #1;
    check1("b2b_v3", out_valid, 1'b0);
    drain("drain_b2b");

    // Vector table, streamed back to back.
    for (int i = 0; i < NVEC; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, '{vecs[i].sum, vecs[i].cout, vecs[i].ovf});
    end
    drain("drain_table");

    // Fill the pipe with downstream stalled, verify freeze, then release.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, golden(ra, rb, rc));
    end
    ra       = {$urandom, $urandom};
    rb       = {$urandom, $urandom};
    rc       = 1'($urandom_range(0, 1));
    in_a     = ra;
    in_b     = rb;
    cin      = rc;
    in_valid = 1'b1;
    @(negedge clk);
    check1("stall_in_ready", in_ready, 1'b0);
    check1("stall_out_valid", out_valid, 1'b1);
    hold_sum  = sum;
    hold_cout = cout;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_sum_hold", sum, hold_sum);
      check1("stall_cout_hold", cout, hold_cout);
      check1("stall_in_ready_hold", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(ra, rb, rc, golden(ra, rb, rc));
    drain("drain_stall");

    // Reset with three ops in flight: none may surface afterwards.
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      send(ra, rb, 1'b0, golden(ra, rb, 1'b0));
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check1("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, '0);
    check1("midrst_cout", cout, 1'b0);
    check1("midrst_in_ready", in_ready, 1'b1);
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkn("midrst_no_stale", seen, 0);

    // Random traffic with random bubbles and backpressure.
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      cin       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) in_a = '1;
      if ($urandom_range(0, 15) == 0) in_b = '1;
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(golden(in_a, in_b, cin));
      @(posedge clk);
      #1;
    end
    drain("drain_random");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, 64, operand width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, 4, pipeline depth; each stage adds one slice of WIDTH/STAGES bits; legal range 1..8.
REQ-003 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  operand set accepted this cycle when in_valid is also high.
REQ-008 in_a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry in.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  (in_a + in_b + cin) mod 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1.
REQ-015 ovf  output  1  signed overflow; present only with CLA_OVF_EN.

Function
REQ-016 Stage k (0..STAGES-1) SHALL add slice k of A and B with carry-lookahead logic and the registered carry from stage k-1; stage 0 uses cin.
REQ-017 Upper operand slices SHALL be skewed with delay registers; lower result slices SHALL be deskewed so sum is aligned on output.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to out_valid, with no stall.
REQ-019 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-020 Pipeline advance = !out_valid || out_ready; all stages move together or all hold.
REQ-021 in_ready SHALL equal advance; combinational, with no dependency on in_valid.
REQ-022 Bubbles (in_valid low) SHALL propagate as invalid slots; results SHALL leave in acceptance order.
REQ-023 While out_valid && !out_ready, sum, cout, ovf SHALL hold stable.
REQ-024 {cout,sum} SHALL equal the full WIDTH+1-bit sum for all inputs, including all-ones + all-ones + 1.
REQ-025 STAGES=1 SHALL yield a single registered CLA, latency 1.

Reset
REQ-026 rst SHALL clear every valid bit, carry register and data register; out_valid, sum, cout, ovf SHALL be 0 the cycle after rst.
REQ-027 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear on the output afterwards.
REQ-028 in_ready SHALL be 1 during and after reset.

Configuration
REQ-029 Macro CLA_OVF_EN defined: ovf port exists and equals carry-into-MSB XOR cout, aligned with sum.
REQ-030 CLA_OVF_EN undefined: ovf port and its pipeline register are absent; other behaviour unchanged.

Structure
REQ-031 Package cla_pkg SHALL hold MAX_STAGES = 8 and the slice-width function, plus a generate-time check that WIDTH % STAGES == 0.
REQ-032 Sub-module cla_slice: combinational N-bit CLA with inputs a, b, ci and outputs s, co, c_msb (carry into top bit); instantiated once per stage.

Verification (WIDTH=64, STAGES=4)
REQ-033 A=FFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> 4 cycles later sum=0, cout=1.
REQ-034 Three back-to-back ops (1+2+0, 5+7+1, 0x8000_0000_0000_0000+0x8000_0000_0000_0000+0), out_ready=1 -> results 3, 13, {cout=1,sum=0} on consecutive cycles 4..6.
REQ-035 Fill pipe, hold out_ready=0 -> in_ready=0, outputs frozen; release -> drains in order with no loss or duplication.
REQ-036 Assert rst with 3 ops in flight -> out_valid=0 the next cycle, no stale result after reset.
REQ-037 CLA_OVF_EN: 7FFF_FFFF_FFFF_FFFF+1+0 -> ovf=1, cout=0; FFFF_FFFF_FFFF_FFFF+1+0 -> ovf=0, cout=1.
REQ-038 1000 random vectors with random in_valid/out_ready -> each result matches golden a+b+cin, in order.
